// File: rtl/ins_mem_responder.sv
// ins_mem_responder
// -----------------------------------------------------------------------------
// Instruction-side memory responder at the far end of the fetch address path.
// After reset the block sits in LOAD and accepts an instruction image from a
// loader over a valid/ready handshake. A single DRAIN cycle separates the final
// write from the first read. After that the block answers fetch addresses with
// one cycle of synchronous-SRAM latency.
//
// Optional feature macro: INS_PARITY_EN
//   When defined, every stored word carries an extra even-parity bit. Each word
//   presented on oFeIns is checked, and a mismatch sets the sticky oParityErr.
//   When undefined, the memory is exactly the data width and oParityErr is 0.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   iInsAddr    fetch word address, sampled every RUN cycle
//   iRstingBlk  fetch-released flag from the PC generator (1 = fetch active)
//   oFeIns      instruction for the address sampled at the previous edge
//   oInsVld     oFeIns holds real memory data
//   iLdVld      loader beat valid
//   oLdRdy      responder accepts a loader beat
//   iLdAddr     loader write word address
//   iLdData     loader write data
//   iLdLast     final beat of the image
//   iReload     single-cycle request to re-enter LOAD from RUN
//   oLdDone     image loaded, block is in RUN
//   oLdCnt      beats accepted since the last LOAD entry (saturating)
//   oParityErr  sticky read parity error
// -----------------------------------------------------------------------------
module ins_mem_responder #(
  parameter int CACHE_WIDTHE = 5,
  parameter int CACHE_DEEPTHE = 12,
  parameter logic [(2**CACHE_WIDTHE)-1:0] NOP_INS = 32'h0000_0013
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CACHE_DEEPTHE-1:0]        iInsAddr,
  input  logic                            iRstingBlk,
  output logic [(2**CACHE_WIDTHE)-1:0]    oFeIns,
  output logic                            oInsVld,
  input  logic                            iLdVld,
  output logic                            oLdRdy,
  input  logic [CACHE_DEEPTHE-1:0]        iLdAddr,
  input  logic [(2**CACHE_WIDTHE)-1:0]    iLdData,
  input  logic                            iLdLast,
  input  logic                            iReload,
  output logic                            oLdDone,
  output logic [CACHE_DEEPTHE:0]          oLdCnt,
  output logic                            oParityErr
);

  localparam int W = 2**CACHE_WIDTHE;
  localparam int DEPTH = 2**CACHE_DEEPTHE;
`ifdef INS_PARITY_EN
  localparam int MW = W + 1;
`else
  localparam int MW = W;
`endif

  // Largest count value: exactly one beat per memory word.
  localparam logic [CACHE_DEEPTHE:0] CNT_MAX = {1'b1, {CACHE_DEEPTHE{1'b0}}};
  localparam logic [CACHE_DEEPTHE:0] CNT_ONE = {{CACHE_DEEPTHE{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    LOAD,
    DRAIN,
    RUN
  } state_t;

  state_t state;
  state_t next_state;

  logic                   ld_rdy;
  logic [CACHE_DEEPTHE:0] ld_cnt;
  logic                   ins_vld;
  logic                   accept;
  logic                   reload;
  logic [MW-1:0]          wr_word;
  logic [MW-1:0]          rd_word;
  logic [MW-1:0]          mem [DEPTH];

  // A beat is accepted only in LOAD while ready is asserted. Ready is held
  // low for the first cycle after reset, so that cycle never writes.
  assign accept = (state == LOAD) && ld_rdy && iLdVld;

  // Reload is honoured only in RUN. In LOAD and DRAIN it is ignored.
  assign reload = (state == RUN) && iReload;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. LOAD leaves only on an accepted last beat. DRAIN always
  // lasts exactly one cycle. RUN returns to LOAD on a reload request.
  always_comb begin
    next_state = state;
    case (state)
      LOAD: begin
        if (accept && iLdLast) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = RUN;
      end
      RUN: begin
        if (reload) begin
          next_state = LOAD;
        end
      end
      default: begin
        next_state = LOAD;
      end
    endcase
  end

  // Handshake, beat counter and fetch-valid registers.
  // Ready is registered from the next state. As a result, it is low during
  // reset and rises one edge after release. It drops on the same edge that
  // moves LOAD to DRAIN. Fetch-valid follows the fetch-release flag only
  // while a real read is taking place, and clears on the reload edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_rdy  <= 1'b0;
      ld_cnt  <= '0;
      ins_vld <= 1'b0;
    end else begin
      ld_rdy  <= (next_state == LOAD);
      ins_vld <= (state == RUN) && !iReload && iRstingBlk;
      if (reload) begin
        ld_cnt <= '0;
      end else if (accept && (ld_cnt != CNT_MAX)) begin
        ld_cnt <= ld_cnt + CNT_ONE;
      end
    end
  end

  // The word written to memory carries the parity bit in its MSB when
  // protection is enabled. The parity bit makes the whole stored word
  // have even parity.
`ifdef INS_PARITY_EN
  assign wr_word = {^iLdData, iLdData};
`else
  assign wr_word = iLdData;
`endif

  // Synchronous single-port memory. It has no reset, so the contents survive
  // reset. Writes happen only in LOAD and reads happen only in RUN. The DRAIN
  // cycle between them means a read never meets an in-flight write.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[iLdAddr] <= wr_word;
    end
    if (state == RUN) begin
      rd_word <= mem[iInsAddr];
    end
  end

  // The NOP substitution sits after the read register. Because of this, an
  // asynchronous reset or a blocked fetch replaces the data at once, and the
  // memory output does not need a reset.
  assign oFeIns  = ins_vld ? rd_word[W-1:0] : NOP_INS;
  assign oInsVld = ins_vld;
  assign oLdRdy  = ld_rdy;
  assign oLdDone = (state == RUN);
  assign oLdCnt  = ld_cnt;

`ifdef INS_PARITY_EN
  logic par_hit;
  logic par_err;

  // Words are checked as they appear on oFeIns. The combinational term raises
  // the flag in the same cycle as the bad data. The sticky register holds the
  // flag until reset.
  assign par_hit = ins_vld && (^rd_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err <= 1'b0;
    end else if (par_hit) begin
      par_err <= 1'b1;
    end
  end

  assign oParityErr = par_err || par_hit;
`else
  assign oParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_ins_mem_responder.sv
// tb_ins_mem_responder
// -----------------------------------------------------------------------------
// Self-checking bench for ins_mem_responder.
// The bench keeps its own picture of the memory as a plain array. It predicts
// every fetch result from that array and from the rule "data for the address
// sampled at the previous edge, or NOP when fetch is blocked".
// -----------------------------------------------------------------------------
module tb_ins_mem_responder;

  localparam int DE = 12;
  localparam int DEPTH = 4096;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] iInsAddr = '0;
  logic        iRstingBlk = 1'b0;
  logic [31:0] oFeIns;
  logic        oInsVld;
  logic        iLdVld = 1'b0;
  logic        oLdRdy;
  logic [11:0] iLdAddr = '0;
  logic [31:0] iLdData = '0;
  logic        iLdLast = 1'b0;
  logic        iReload = 1'b0;
  logic        oLdDone;
  logic [12:0] oLdCnt;
  logic        oParityErr;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [11:0] addr;
    logic        blk;
    logic [31:0] exp_ins;
    logic        exp_vld;
  } vec_t;

  vec_t vecs [8];

  ins_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .iInsAddr   (iInsAddr),
    .iRstingBlk (iRstingBlk),
    .oFeIns     (oFeIns),
    .oInsVld    (oInsVld),
    .iLdVld     (iLdVld),
    .oLdRdy     (oLdRdy),
    .iLdAddr    (iLdAddr),
    .iLdData    (iLdData),
    .iLdLast    (iLdLast),
    .iReload    (iReload),
    .oLdDone    (oLdDone),
    .oLdCnt     (oLdCnt),
    .oParityErr (oParityErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [31:0] ins, input logic vld,
                            input logic rdy, input logic done, input logic [12:0] cnt);
    checkOutput({tag, " ins"}, oFeIns, ins);
    checkOutput({tag, " vld"}, 32'(oInsVld), 32'(vld));
    checkOutput({tag, " rdy"}, 32'(oLdRdy), 32'(rdy));
    checkOutput({tag, " done"}, 32'(oLdDone), 32'(done));
    checkOutput({tag, " cnt"}, 32'(oLdCnt), 32'(cnt));
  endtask

  task automatic applyStimulus(input logic [11:0] ins_addr, input logic blk, input logic ld_vld,
                               input logic [11:0] ld_addr, input logic [31:0] ld_data,
                               input logic ld_last, input logic reload);
    iInsAddr   = ins_addr;
    iRstingBlk = blk;
    iLdVld     = ld_vld;
    iLdAddr    = ld_addr;
    iLdData    = ld_data;
    iLdLast    = ld_last;
    iReload    = reload;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int accepted;
    logic        v;
    logic [11:0] a;
    logic [31:0] d;
    logic        l;
    logic        b;

    // Reset state
    applyStimulus('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step();
    step();
    checkState("reset", NOP, 1'b0, 1'b0, 1'b0, 13'd0);
    checkOutput("reset perr", 32'(oParityErr), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rdy before first edge", 32'(oLdRdy), 32'd0);
    step();
    checkState("first cycle", NOP, 1'b0, 1'b1, 1'b0, 13'd0);

    // Load four beats
    for (int i = 0; i < 4; i++) begin
      d = 32'h1111_1111 * (i + 1);
      model_mem[i] = d;
      applyStimulus(12'd0, 1'b1, 1'b1, 12'(i), d, (i == 3), 1'b0);
      step();
      if (i < 3) checkState("load beat", NOP, 1'b0, 1'b1, 1'b0, 13'(i + 1));
    end
    checkState("drain", NOP, 1'b0, 1'b0, 1'b0, 13'd4);
    applyStimulus('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkState("run entry", NOP, 1'b0, 1'b0, 1'b1, 13'd4);

    // Table-driven reads
    vecs[0] = '{12'd2, 1'b1, 32'h3333_3333, 1'b1};
    vecs[1] = '{12'd0, 1'b1, 32'h1111_1111, 1'b1};
    vecs[2] = '{12'd1, 1'b1, 32'h2222_2222, 1'b1};
    vecs[3] = '{12'd3, 1'b1, 32'h4444_4444, 1'b1};
    vecs[4] = '{12'd1, 1'b0, NOP,           1'b0};
    vecs[5] = '{12'd2, 1'b1, 32'h3333_3333, 1'b1};
    vecs[6] = '{12'd3, 1'b0, NOP,           1'b0};
    vecs[7] = '{12'd0, 1'b1, 32'h1111_1111, 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].blk, 1'b0, '0, '0, 1'b0, 1'b0);
      step();
      checkOutput($sformatf("vec%0d ins", i), oFeIns, vecs[i].exp_ins);
      checkOutput($sformatf("vec%0d vld", i), 32'(oInsVld), 32'(vecs[i].exp_vld));
    end

    // Reload collides with a loader beat. The beat must be dropped.
    applyStimulus(12'd0, 1'b1, 1'b1, 12'd2, 32'hBADC_0FFE, 1'b1, 1'b1);
    step();
    checkState("reload", NOP, 1'b0, 1'b1, 1'b0, 13'd0);
    // Last without valid, and reload while in LOAD, both have no effect.
    applyStimulus(12'd0, 1'b1, 1'b0, 12'd3, 32'h0, 1'b1, 1'b1);
    step();
    checkState("load idle", NOP, 1'b0, 1'b1, 1'b0, 13'd0);
    applyStimulus(12'd0, 1'b0, 1'b1, 12'd1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    model_mem[1] = 32'hDEAD_BEEF;
    step();
    checkState("drain2", NOP, 1'b0, 1'b0, 1'b0, 13'd1);
    // Reload during DRAIN is ignored.
    applyStimulus(12'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    step();
    checkState("run2", NOP, 1'b0, 1'b0, 1'b1, 13'd1);
    applyStimulus(12'd1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkOutput("reloaded addr1", oFeIns, 32'hDEAD_BEEF);
    applyStimulus(12'd2, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkOutput("collision not written", oFeIns, 32'h3333_3333);
    applyStimulus(12'd3, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkOutput("addr3 before rst", oFeIns, 32'h4444_4444);

    // Asynchronous reset in RUN between clock edges
    #2 rst = 1'b1;
    #1;
    checkState("rst mid-run", NOP, 1'b0, 1'b0, 1'b0, 13'd0);
    step();
    rst = 1'b0;
    step();
    checkState("after rst1", NOP, 1'b0, 1'b1, 1'b0, 13'd0);

    // Asynchronous reset in LOAD after two beats
    for (int i = 0; i < 2; i++) begin
      applyStimulus('0, 1'b0, 1'b1, 12'(i), 32'hA5A5_0000 + 32'(i), 1'b0, 1'b0);
      model_mem[i] = 32'hA5A5_0000 + 32'(i);
      step();
    end
    checkOutput("cnt before rst", 32'(oLdCnt), 32'd2);
    applyStimulus('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkState("rst mid-load", NOP, 1'b0, 1'b0, 1'b0, 13'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rdy held after release", 32'(oLdRdy), 32'd0);
    step();
    checkState("after rst2", NOP, 1'b0, 1'b1, 1'b0, 13'd0);

    // Randomized full-memory load that drives the counter into saturation
    accepted = 0;
    while (accepted < DEPTH + 1) begin
      v = ($urandom_range(0, 3) != 0);
      a = (accepted < DEPTH) ? 12'(accepted) : 12'($urandom_range(0, DEPTH - 1));
      d = $urandom;
      l = v ? (accepted == DEPTH) : 1'($urandom_range(0, 1));
      applyStimulus(12'($urandom), 1'($urandom), v, a, d, l, 1'($urandom));
      step();
      if (v) begin
        model_mem[a] = d;
        accepted++;
      end
      checkOutput("sat cnt", 32'(oLdCnt), (accepted > DEPTH) ? DEPTH : accepted);
      checkOutput("load rdy", 32'(oLdRdy), 32'(!(v && l)));
    end
    applyStimulus('0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkState("run3", NOP, 1'b0, 1'b0, 1'b1, 13'(DEPTH));

    // Randomized fetches checked against the bench memory image
    for (int i = 0; i < 300; i++) begin
      a = 12'($urandom_range(0, DEPTH - 1));
      b = ($urandom_range(0, 3) != 0);
      applyStimulus(a, b, 1'($urandom), 12'($urandom), $urandom, 1'($urandom), 1'b0);
      step();
      checkOutput("rand ins", oFeIns, b ? model_mem[a] : NOP);
      checkOutput("rand vld", 32'(oInsVld), 32'(b));
    end
    checkOutput("perr clean", 32'(oParityErr), 32'd0);

    // Parity error injection
`ifdef INS_PARITY_EN
    dut.mem[0][32] = ~dut.mem[0][32];
    applyStimulus(12'd0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkOutput("perr data cycle", 32'(oParityErr), 32'd1);
    checkOutput("perr raw data", oFeIns, model_mem[0]);
    applyStimulus(12'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("perr sticky", 32'(oParityErr), 32'd1);
`else
    applyStimulus(12'd0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    step();
    checkOutput("perr off data", 32'(oParityErr), 32'd0);
    checkOutput("perr off ins", oFeIns, model_mem[0]);
    applyStimulus(12'd0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step();
    checkOutput("perr off later", 32'(oParityErr), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
